// File: rtl/pla_dump_pkg.sv
// ---------------------------------------------------------------------------
// pla_dump_pkg
//   Shared definitions for the PLA dump sequencer:
//     - FSM state encoding (IDLE, SETTLE, SAMPLE, EMIT, DONE)
//     - CRC-16/CCITT constants and a byte-update helper
//     - default settle time
//   The CRC helper is only referenced when DUMP_CRC_EN is defined.
// ---------------------------------------------------------------------------
package pla_dump_pkg;

  // FSM encoding kept as plain constants so the state register is a simple
  // logic vector that older tools and netlist viewers handle without fuss.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SETTLE = 3'd1;
  localparam state_t ST_SAMPLE = 3'd2;
  localparam state_t ST_EMIT   = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  // CRC-16/CCITT: poly 0x1021, init 0xFFFF, MSB first, no final xor.
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Settle time in clk cycles; covers the 2-flop synchroniser plus PLA
  // propagation through the socket. Must be at least 3.
  localparam int DEFAULT_SETTLE_CYCLES = 8;

  // Fold one byte into the running CRC, MSB first.
  function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc,
                                                   input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int b = 0; b < 8; b++) begin
      if (c[15]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else       c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/pla_dump_sequencer_if.sv
// ---------------------------------------------------------------------------
// pla_dump_sequencer_if
//   Record stream from the dump sequencer to the host-link dumper.
//   Signals:
//     valid  record available (source -> sink)
//     ready  sink accepts record when valid && ready (sink -> source)
//     addr   PLA input vector of the record
//     data   sampled PLA outputs for addr
//   Modports: master (sequencer side), slave (dumper side).
// ---------------------------------------------------------------------------
interface pla_dump_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/pla_in_sync.sv
// ---------------------------------------------------------------------------
// pla_in_sync
//   W-bit wide two-flop synchroniser for the raw PLA outputs, which change
//   asynchronously to clk after each new input vector. Each bit is
//   synchronised independently; the settle time guarantees all bits are
//   stable long before the sequencer samples them, so bit skew is harmless.
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset (flops clear to 0)
//     d    asynchronous input bus
//     q    synchronised output bus
// ---------------------------------------------------------------------------
module pla_in_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pla_dump_sequencer.sv
// ---------------------------------------------------------------------------
// pla_dump_sequencer
//   Reader side of the PLA test socket. Walks every input vector
//   0 .. 2^ADDR_W-1 onto the PLA, waits SETTLE_CYCLES, samples the
//   synchronised PLA outputs and offers an (addr, data) record on a
//   valid/ready stream. One record is in flight at a time.
//
//   Ports:
//     clk      system clock
//     rst      asynchronous active-high reset
//     start    pulse: begin dump at vector 0 (only from IDLE or DONE)
//     abort    pulse: drop everything and return to IDLE (beats start)
//     pla_i    vector driven onto the PLA inputs
//     pla_f    raw PLA outputs, asynchronous to clk
//     out      record stream (master modport of pla_dump_sequencer_if)
//     busy     high in SETTLE / SAMPLE / EMIT
//     done     sticky after the last record is accepted
//     crc_out  running CRC-16/CCITT of accepted data bytes
//
//   Optional feature: define DUMP_CRC_EN to build the CRC; without it
//   crc_out is tied to zero and no CRC logic exists.
// ---------------------------------------------------------------------------
module pla_dump_sequencer
  import pla_dump_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  output logic [ADDR_W-1:0]       pla_i,
  input  logic [DATA_W-1:0]       pla_f,
  pla_dump_sequencer_if.master    out,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             crc_out
);

  // Counter loads SETTLE_CYCLES-1 and counts down to 0, so SETTLE lasts
  // exactly SETTLE_CYCLES cycles.
  localparam int                CNT_W      = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t            state_reg,    state_next;
  logic [ADDR_W-1:0] addr_reg,     addr_next;
  logic [CNT_W-1:0]  cnt_reg,      cnt_next;
  logic              valid_reg,    valid_next;
  logic [ADDR_W-1:0] rec_addr_reg, rec_addr_next;
  logic [DATA_W-1:0] rec_data_reg, rec_data_next;
  logic              done_reg,     done_next;

  logic [DATA_W-1:0] pla_f_sync;
  logic              idle_or_done;
  logic              accept;
  logic              last_vec;

  pla_in_sync #(.W(DATA_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pla_f),
    .q   (pla_f_sync)
  );

  assign idle_or_done = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign accept       = (state_reg == ST_EMIT) && out.ready;
  // Terminal vector is detected by compare, so the address never wraps.
  assign last_vec     = &addr_reg;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    cnt_next      = cnt_reg;
    valid_next    = valid_reg;
    rec_addr_next = rec_addr_reg;
    rec_data_next = rec_data_reg;
    done_next     = done_reg;

    if (abort) begin
      // Abort drops the pending record without a handshake and parks the
      // PLA inputs at vector 0.
      state_next = ST_IDLE;
      addr_next  = '0;
      valid_next = 1'b0;
      done_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_next = ST_SETTLE;
            addr_next  = '0;
            cnt_next   = CNT_RELOAD;
            done_next  = 1'b0;
          end
        end

        ST_SETTLE: begin
          if (cnt_reg == '0) state_next = ST_SAMPLE;
          else               cnt_next   = cnt_reg - 1'b1;
        end

        ST_SAMPLE: begin
          rec_data_next = pla_f_sync;
          rec_addr_next = addr_reg;
          valid_next    = 1'b1;
          state_next    = ST_EMIT;
        end

        ST_EMIT: begin
          if (out.ready) begin
            valid_next = 1'b0;
            if (last_vec) begin
              // Hold the last vector on the PLA so the socket is static.
              state_next = ST_DONE;
              done_next  = 1'b1;
            end else begin
              // New vector goes out on the accepting edge; settle restarts.
              addr_next  = addr_reg + ADDR_W'(1);
              cnt_next   = CNT_RELOAD;
              state_next = ST_SETTLE;
            end
          end
        end

        default: begin
          state_next = ST_IDLE;
          addr_next  = '0;
          valid_next = 1'b0;
          done_next  = 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      cnt_reg      <= '0;
      valid_reg    <= 1'b0;
      rec_addr_reg <= '0;
      rec_data_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      cnt_reg      <= cnt_next;
      valid_reg    <= valid_next;
      rec_addr_reg <= rec_addr_next;
      rec_data_reg <= rec_data_next;
      done_reg     <= done_next;
    end
  end

  // -------------------------------------------------------------------------
  // Optional CRC over accepted data bytes
  // -------------------------------------------------------------------------
`ifdef DUMP_CRC_EN
  logic [15:0] crc_reg, crc_next;

  always_comb begin
    crc_next = crc_reg;
    if (!abort) begin
      if (idle_or_done && start) crc_next = CRC_INIT;
      else if (accept)           crc_next = crc16_ccitt_byte(crc_reg, 8'(rec_data_reg));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_reg <= '0;
    else     crc_reg <= crc_next;
  end

  assign crc_out = crc_reg;
`else
  assign crc_out = 16'h0000;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign pla_i     = addr_reg;
  assign out.valid = valid_reg;
  assign out.addr  = rec_addr_reg;
  assign out.data  = rec_data_reg;
  assign done      = done_reg;
  assign busy      = (state_reg == ST_SETTLE) || (state_reg == ST_SAMPLE) ||
                     (state_reg == ST_EMIT);

endmodule

// File: tb/tb_pla_dump_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pla_dump_sequencer
//   Directed bench for pla_dump_sequencer with an 8-input PLA model so that
//   complete dumps fit in a short run. Checks reset state, full dumps with
//   and without backpressure, settle latency, record stability under
//   backpressure, start-while-busy, abort priority, asynchronous reset in
//   SETTLE at the last vector, and the CRC result (zero when DUMP_CRC_EN is
//   not defined).
// ---------------------------------------------------------------------------
module tb_pla_dump_sequencer;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int SC   = 8;
  localparam int NVEC = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] pla_i;
  logic [DW-1:0] pla_f;
  logic          busy;
  logic          done;
  logic [15:0]   crc_out;
  bit            const_mode = 1'b0;

  int            total = 0;
  int            bad   = 0;
  logic [15:0]   crc_m;

  pla_dump_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) out_if ();

  pla_dump_sequencer #(
    .SETTLE_CYCLES (SC),
    .ADDR_W        (AW),
    .DATA_W        (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .pla_i   (pla_i),
    .pla_f   (pla_f),
    .out     (out_if.master),
    .busy    (busy),
    .done    (done),
    .crc_out (crc_out)
  );

  always #5 clk = ~clk;

  // Deliberately irregular PLA equations.
  function automatic logic [7:0] model(input logic [7:0] a);
    logic [7:0] f;
    f[0] = (a[0] & a[1]) | ~a[7];
    f[1] = a[2] ^ a[5];
    f[2] = &a[3:0];
    f[3] = (|a[7:4]) & ~a[2];
    f[4] = a[6] ~^ a[1];
    f[5] = ^a;
    f[6] = a[7] & a[6] & ~a[0];
    f[7] = ~(a[4] | a[3]);
    return f;
  endfunction

  assign pla_f = const_mode ? 8'hFF : model(pla_i);

  function automatic logic [7:0] expect_data(input logic [7:0] a);
    return const_mode ? 8'hFF : model(a);
  endfunction

  // Bit-serial CRC-16/CCITT reference.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic logic [15:0] expect_crc(input logic [15:0] model_crc);
`ifdef DUMP_CRC_EN
    return model_crc;
`else
    return 16'h0000 & model_crc;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    crc_m = 16'hFFFF;
    chk("start_busy",  busy,    1);
    chk("start_pla_i", pla_i,   0);
    chk("start_done",  done,    0);
    chk("start_crc",   crc_out, expect_crc(crc_m));
  endtask

  // Consume records until all vectors are accepted, or stop (without
  // accepting) when the record for stop_at is first offered.
  task automatic run_dump(input int duty, input int stop_at);
    int            exp_addr = 0;
    int            lat      = 0;
    int            guard    = 0;
    logic [AW-1:0] last_pla;
    logic [AW-1:0] held_a;
    logic [DW-1:0] held_d;
    bit            holding  = 1'b0;
    bit            stopped  = 1'b0;
    last_pla = pla_i;
    while (exp_addr < NVEC && guard < 20000 && !stopped) begin
      if (out_if.valid) begin
        if (!holding) begin
          chk("rec_addr",   out_if.addr, exp_addr);
          chk("rec_data",   out_if.data, expect_data(8'(exp_addr)));
          chk("rec_pla_i",  pla_i,       exp_addr);
          chk("latency",    lat,         SC + 1);
          holding = 1'b1;
          held_a  = out_if.addr;
          held_d  = out_if.data;
        end else begin
          chk("hold_addr", out_if.addr, held_a);
          chk("hold_data", out_if.data, held_d);
        end
        if (exp_addr == stop_at) stopped = 1'b1;
      end
      if (!stopped) begin
        out_if.ready = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
        if (out_if.valid && out_if.ready) begin
          crc_m   = crc_step(crc_m, held_d);
          exp_addr++;
          holding = 1'b0;
        end
        step();
        guard++;
        lat++;
        if (pla_i != last_pla) begin
          lat      = 0;
          last_pla = pla_i;
        end
      end
    end
    out_if.ready = 1'b0;
    if (stop_at < 0) begin
      chk("all_records", exp_addr,     NVEC);
      chk("end_done",    done,         1);
      chk("end_valid",   out_if.valid, 0);
      chk("end_busy",    busy,         0);
      chk("end_pla_i",   pla_i,        NVEC - 1);
      chk("end_crc",     crc_out,      expect_crc(crc_m));
    end else begin
      chk("reached_stop", stopped, 1);
    end
  endtask

  initial begin
    logic [15:0] golden;
    out_if.ready = 1'b0;
    crc_m        = 16'hFFFF;

    // Reset state
    #12;
    chk("rst_pla_i", pla_i,        0);
    chk("rst_valid", out_if.valid, 0);
    chk("rst_addr",  out_if.addr,  0);
    chk("rst_data",  out_if.data,  0);
    chk("rst_busy",  busy,         0);
    chk("rst_done",  done,         0);
    chk("rst_crc",   crc_out,      0);
    step();
    rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    // Full dump, sink always ready
    do_start();
    run_dump(100, -1);

    // DONE is sticky and holds the last vector
    step(); step(); step();
    chk("done_sticky", done,  1);
    chk("done_pla_i",  pla_i, NVEC - 1);
    chk("done_busy",   busy,  0);

    // Restart from DONE with ~30% ready duty
    do_start();
    run_dump(30, -1);

    // Abort in EMIT, after a start that must be ignored
    do_start();
    run_dump(100, 'h34);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_valid", out_if.valid, 1);
    chk("busy_start_addr",  out_if.addr,  'h34);
    chk("busy_start_pla_i", pla_i,        'h34);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_valid", out_if.valid, 0);
    chk("abort_pla_i", pla_i,        0);
    chk("abort_done",  done,         0);
    chk("abort_busy",  busy,         0);
    step(); step();
    chk("abort_stays_idle", busy, 0);

    // Async reset while settling the last vector
    do_start();
    run_dump(100, NVEC - 2);
    out_if.ready = 1'b1;
    step();
    out_if.ready = 1'b0;
    chk("pre_rst_pla_i", pla_i, NVEC - 1);
    step(); step(); step();
    chk("pre_rst_busy",  busy,         1);
    chk("pre_rst_valid", out_if.valid, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pla_i", pla_i,        0);
    chk("arst_valid", out_if.valid, 0);
    chk("arst_addr",  out_if.addr,  0);
    chk("arst_data",  out_if.data,  0);
    chk("arst_busy",  busy,         0);
    chk("arst_done",  done,         0);
    chk("arst_crc",   crc_out,      0);
    step();
    rst = 1'b0;
    step();

    // Full dump of a constant-0xFF PLA, CRC against golden
    const_mode = 1'b1;
    step(); step(); step();
    do_start();
    run_dump(100, -1);
    golden = 16'hFFFF;
    for (int i = 0; i < NVEC; i++) golden = crc_step(golden, 8'hFF);
    chk("crc_golden", crc_out, expect_crc(golden));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
